// File: rtl/router_pkt_tx_if.sv
// Source-side bundle of router_pkt_tx: the local payload byte stream in, and
// the byte bus out to the router input port with its busy/err feedback.
interface router_pkt_tx_if;
  logic [7:0] src_data;
  logic       src_valid;
  logic       src_ready;
  logic [7:0] data_out;
  logic       pkt_valid;
  logic       busy;
  logic       err;

  modport master (
    input  src_data,
    input  src_valid,
    output src_ready,
    output data_out,
    output pkt_valid,
    input  busy,
    input  err
  );

  modport slave (
    output src_data,
    output src_valid,
    input  src_ready,
    input  data_out,
    input  pkt_valid,
    output busy,
    output err
  );
endinterface

// File: rtl/router_pkt_tx.sv
// Packet transmitter: buffers a payload from the local stream, then sends
// header, payload and parity to the router and reports the err outcome.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   IDLE    | tx_ready=1, waiting for start; illegal requests pulse req_err
//   LOAD    | src_ready=1, filling pbuf until len bytes are captured
//   HEADER  | {len,addr} on data_out, pkt_valid=1, waits for busy=0
//   PAYLOAD | pbuf[rd_cnt] on data_out, pkt_valid=1, one byte per free cycle
//   PARITY  | running XOR (optionally inverted) on data_out, pkt_valid=0
//   CHECK   | samples err for ERR_WAIT cycles, then pulses tx_done
module router_pkt_tx #(
  parameter int MAX_LEN  = 63,
  parameter int ERR_WAIT = 3
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic            start,
  input  logic [1:0]      dest_addr,
  input  logic [5:0]      payload_len,
  input  logic            inject_err,
  output logic            tx_ready,
  output logic            req_err,
  output logic            tx_done,
  output logic            tx_err,
  router_pkt_tx_if.master bus
);

  localparam logic [6:0] MAX_LEN_W = 7'(MAX_LEN);
  localparam logic [7:0] WAIT_LAST = 8'(ERR_WAIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_HEADER,
    S_PAYLOAD,
    S_PARITY,
    S_CHECK
  } state_t;

  state_t     state;
  logic [1:0] addr_q;
  logic [5:0] len_q;
  logic       inj_q;
  logic [5:0] wr_cnt;
  logic [5:0] rd_cnt;
  logic [7:0] parity;
  logic [7:0] wcnt;
  logic       err_seen;
  logic [7:0] pbuf [64];

  logic [5:0] len_last;
  logic       bad_req;
  logic       src_take;

  assign len_last = len_q - 6'd1;
  assign bad_req  = (dest_addr == 2'd3) || (payload_len == 6'd0) ||
                    ({1'b0, payload_len} > MAX_LEN_W);
  assign src_take = (state == S_LOAD) && bus.src_valid && bus.src_ready;

  // Payload storage needs no reset; contents are rewritten before every use.
  always_ff @(posedge clock) begin
    if (src_take) begin
      pbuf[wr_cnt] <= bus.src_data;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state         <= S_IDLE;
      addr_q        <= 2'd0;
      len_q         <= 6'd0;
      inj_q         <= 1'b0;
      wr_cnt        <= 6'd0;
      rd_cnt        <= 6'd0;
      parity        <= 8'd0;
      wcnt          <= 8'd0;
      err_seen      <= 1'b0;
      bus.data_out  <= 8'd0;
      bus.pkt_valid <= 1'b0;
      bus.src_ready <= 1'b0;
      tx_ready      <= 1'b1;
      req_err       <= 1'b0;
      tx_done       <= 1'b0;
      tx_err        <= 1'b0;
    end else begin
      req_err <= 1'b0;
      tx_done <= 1'b0;
      tx_err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            addr_q <= dest_addr;
            len_q  <= payload_len;
            inj_q  <= inject_err;
            if (bad_req) begin
              req_err <= 1'b1;
            end else begin
              state         <= S_LOAD;
              wr_cnt        <= 6'd0;
              tx_ready      <= 1'b0;
              bus.src_ready <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (src_take) begin
            wr_cnt <= wr_cnt + 6'd1;
            if (wr_cnt == len_last) begin
              state         <= S_HEADER;
              bus.src_ready <= 1'b0;
              bus.data_out  <= {len_q, addr_q};
              bus.pkt_valid <= 1'b1;
            end
          end
        end
        S_HEADER: begin
          if (!bus.busy) begin
            parity       <= bus.data_out;
            rd_cnt       <= 6'd0;
            state        <= S_PAYLOAD;
            bus.data_out <= pbuf[0];
          end
        end
        S_PAYLOAD: begin
          if (!bus.busy) begin
            parity <= parity ^ bus.data_out;
            rd_cnt <= rd_cnt + 6'd1;
            if (rd_cnt == len_last) begin
              // Final payload byte folds into the parity byte in the same edge.
              state         <= S_PARITY;
              bus.data_out  <= parity ^ bus.data_out ^ {8{inj_q}};
              bus.pkt_valid <= 1'b0;
            end else begin
              bus.data_out <= pbuf[rd_cnt + 6'd1];
            end
          end
        end
        S_PARITY: begin
          if (!bus.busy) begin
            state        <= S_CHECK;
            bus.data_out <= 8'd0;
            wcnt         <= 8'd0;
            err_seen     <= 1'b0;
          end
        end
        S_CHECK: begin
          if (wcnt == WAIT_LAST) begin
            state    <= S_IDLE;
            tx_ready <= 1'b1;
            tx_done  <= 1'b1;
            tx_err   <= err_seen | bus.err;
          end else begin
            err_seen <= err_seen | bus.err;
            wcnt     <= wcnt + 8'd1;
          end
        end
        default: begin
          state         <= S_IDLE;
          tx_ready      <= 1'b1;
          bus.src_ready <= 1'b0;
          bus.pkt_valid <= 1'b0;
          bus.data_out  <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Bench for router_pkt_tx: directed and randomized packets against a packet-level
// reference (expected byte list plus a router model that checks parity).
module tb_router_pkt_tx;
  localparam int MAX_LEN  = 63;
  localparam int ERR_WAIT = 3;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic [1:0] dest_addr = 2'd0;
  logic [5:0] payload_len = 6'd0;
  logic       inject_err = 1'b0;
  logic       tx_ready, req_err, tx_done, tx_err;

  router_pkt_tx_if bus_if ();

  router_pkt_tx #(.MAX_LEN(MAX_LEN), .ERR_WAIT(ERR_WAIT)) dut (
    .clock       (clock),
    .resetn      (resetn),
    .start       (start),
    .dest_addr   (dest_addr),
    .payload_len (payload_len),
    .inject_err  (inject_err),
    .tx_ready    (tx_ready),
    .req_err     (req_err),
    .tx_done     (tx_done),
    .tx_err      (tx_err),
    .bus         (bus_if)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [7:0] pay_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    cyc++;
  endtask

  task automatic illegal(input logic [1:0] addr, input logic [5:0] len);
    chk("illegal_pre_ready", tx_ready, 1);
    start = 1'b1; dest_addr = addr; payload_len = len;
    tick();
    start = 1'b0;
    chk("req_err_pulse", req_err, 1);
    chk("illegal_ready", tx_ready, 1);
    chk("illegal_pv", bus_if.pkt_valid, 0);
    chk("illegal_src_ready", bus_if.src_ready, 0);
    tick();
    chk("req_err_clear", req_err, 0);
    chk("illegal_ready2", tx_ready, 1);
    chk("illegal_pv2", bus_if.pkt_valid, 0);
  endtask

  // One packet, start to tx_done; returns on the tx_done cycle so the next
  // call can start back-to-back. reset_k >= 0 resets while byte reset_k is shown.
  task automatic run_pkt(input logic [1:0] addr, input logic [5:0] len, input logic inj,
                         input int gap_pct, input int busy_pct,
                         input int stall_k, input int stall_len, input int reset_k);
    logic [7:0] pay[$];
    logic [7:0] exp_q[$];
    logic [7:0] par, rx_par, d;
    logic       v, r, b, rtr_err;
    int idx, k, budget, stall_left, cyc0, seen;

    pay = pay_q;
    pay_q.delete();
    if (pay.size() != int'(len)) begin
      pay.delete();
      for (int i = 0; i < int'(len); i++) pay.push_back(8'($urandom_range(255)));
    end
    exp_q.delete();
    par = {len, addr};
    exp_q.push_back(par);
    foreach (pay[i]) begin
      exp_q.push_back(pay[i]);
      par = par ^ pay[i];
    end
    exp_q.push_back(inj ? ~par : par);

    budget = 0;
    while (!tx_ready && budget < 50) begin tick(); budget++; end
    chk("idle_ready", tx_ready, 1);
    start = 1'b1; dest_addr = addr; payload_len = len; inject_err = inj;
    cyc0 = cyc;
    tick();
    dest_addr = 2'($urandom); payload_len = 6'($urandom); inject_err = 1'($urandom);
    chk("load_src_ready", bus_if.src_ready, 1);
    chk("load_tx_ready", tx_ready, 0);
    chk("load_done_low", tx_done, 0);

    idx = 0; budget = 0;
    while (idx < int'(len) && budget < 2000) begin
      r = bus_if.src_ready;
      v = ($urandom_range(99) >= gap_pct);
      bus_if.src_valid = v;
      bus_if.src_data  = v ? pay[idx] : 8'($urandom);
      bus_if.err  = 1'($urandom);
      bus_if.busy = 1'($urandom);
      start = 1'($urandom);
      tick(); budget++;
      if (r && v) idx++;
    end
    bus_if.src_valid = 1'b0; bus_if.err = 1'b0; bus_if.busy = 1'b0;
    if (idx < int'(len)) begin chk("load_timeout", idx, len); start = 1'b0; return; end

    k = 0; budget = 0; stall_left = stall_len; rx_par = 8'd0; rtr_err = 1'b0;
    while (k < int'(len) + 2 && budget < 2000) begin
      d = bus_if.data_out;
      chk($sformatf("byte%0d", k), d, exp_q[k]);
      chk($sformatf("pv%0d", k), bus_if.pkt_valid, (k <= int'(len)));
      if (k == reset_k) begin
        start = 1'b0; resetn = 1'b0;
        tick();
        resetn = 1'b1;
        chk("rst_pv", bus_if.pkt_valid, 0);
        chk("rst_data", bus_if.data_out, 0);
        chk("rst_ready", tx_ready, 1);
        chk("rst_src_ready", bus_if.src_ready, 0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
          if (tx_done) seen++;
          tick();
        end
        chk("rst_no_done", seen, 0);
        return;
      end
      if (k == stall_k && stall_left > 0) begin b = 1'b1; stall_left--; end
      else b = ($urandom_range(99) < busy_pct);
      bus_if.busy = b;
      bus_if.err  = 1'($urandom);
      start = 1'($urandom);
      tick(); budget++;
      if (!b) begin
        if (k <= int'(len)) rx_par = rx_par ^ d;
        else rtr_err = (d != rx_par);
        k++;
      end
    end
    bus_if.busy = 1'b0; bus_if.err = 1'b0; start = 1'b0;
    if (k < int'(len) + 2) begin chk("tx_timeout", k, len + 2); return; end

    for (int c = 1; c <= ERR_WAIT; c++) begin
      chk("check_no_done", tx_done, 0);
      chk("check_data", bus_if.data_out, 0);
      bus_if.err  = rtr_err && (c == 2);
      bus_if.busy = 1'($urandom);
      tick();
    end
    bus_if.err = 1'b0; bus_if.busy = 1'b0;
    chk("tx_done", tx_done, 1);
    chk("tx_err", tx_err, inj);
    chk("done_ready", tx_ready, 1);
    chk("done_pv", bus_if.pkt_valid, 0);
    if (gap_pct == 0 && busy_pct == 0 && stall_k < 0)
      chk("latency", cyc - cyc0, 1 + 2 * int'(len) + 2 + ERR_WAIT);
  endtask

  initial begin
    bus_if.src_data = 8'd0; bus_if.src_valid = 1'b0;
    bus_if.busy = 1'b0; bus_if.err = 1'b0;
    tick(); tick();
    chk("rst_data_out", bus_if.data_out, 0);
    chk("rst_pkt_valid", bus_if.pkt_valid, 0);
    chk("rst_src_ready0", bus_if.src_ready, 0);
    chk("rst_req_err", req_err, 0);
    chk("rst_tx_done", tx_done, 0);
    chk("rst_tx_err", tx_err, 0);
    chk("rst_tx_ready", tx_ready, 1);
    resetn = 1'b1;
    tick();

    pay_q = {8'hA5, 8'h3C};
    run_pkt(2'd1, 6'd2, 1'b0, 0, 0, -1, 0, -1);
    pay_q = {8'hA5, 8'h3C};
    run_pkt(2'd1, 6'd2, 1'b0, 0, 0, 1, 4, -1);
    tick();
    illegal(2'd3, 6'd5);
    illegal(2'd0, 6'd0);
    pay_q = {8'hA5, 8'h3C};
    run_pkt(2'd1, 6'd2, 1'b1, 0, 0, -1, 0, -1);
    run_pkt(2'd2, 6'd63, 1'b0, 50, 0, -1, 0, -1);
    run_pkt(2'd0, 6'd20, 1'b0, 0, 0, -1, 0, 11);
    pay_q = {8'hA5, 8'h3C};
    run_pkt(2'd1, 6'd2, 1'b0, 0, 0, -1, 0, -1);
    run_pkt(2'd0, 6'd1, 1'b0, 0, 0, -1, 0, -1);
    for (int n = 0; n < 6; n++) begin
      run_pkt(2'($urandom_range(2)), 6'($urandom_range(MAX_LEN, 1)), 1'($urandom),
              30, 30, -1, 0, -1);
    end
    tick();
    chk("done_one_cycle", tx_done, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/router_pkt_tx.md
Name: router_pkt_tx

Overview:
Source-side packet transmitter that drives the router's input port.
- Collects a payload from a local byte stream into an internal buffer.
- Emits the packet as a header byte, then payload bytes, then a parity byte, honouring router `busy`.
- Watches router `err` after the parity byte and reports the packet outcome.
- Serves as the traffic generator in the router testbench and in the source-side wrapper.

Parameters:
MAX_LEN, 63, largest legal payload length; the header length field is 6 bits, so MAX_LEN must be ≤63.
ERR_WAIT, 3, number of cycles `err` is sampled after the parity byte is accepted.

Ports:
clock  in  1  system clock, rising edge
resetn  in  1  synchronous active-low reset
start  in  1  request to send a packet; sampled only when tx_ready=1
dest_addr  in  2  destination port 0..2; 3 is illegal
payload_len  in  6  payload byte count, 1..MAX_LEN
inject_err  in  1  latched at start; inverts the transmitted parity byte
src_data  in  8  payload byte stream
src_valid  in  1  src_data valid
src_ready  out  1  transmitter accepts src_data this cycle
data_out  out  8  byte to router
pkt_valid  out  1  high during header and payload bytes, low during the parity byte
busy  in  1  router stall; data_out must be held while busy=1
err  in  1  router parity-error indication
tx_ready  out  1  idle, can accept start
req_err  out  1  one-cycle pulse: start rejected
tx_done  out  1  one-cycle pulse: packet finished
tx_err  out  1  packet error result; valid only while tx_done=1

Behaviour:
- Reset: synchronous active-low on resetn.
  - State goes to IDLE.
  - Outputs: data_out=0, pkt_valid=0, src_ready=0, req_err=0, tx_done=0, tx_err=0, tx_ready=1.
  - All counters and the parity accumulator clear; buffer contents are don't-care.
  - Reset mid-packet abandons the packet silently: no tx_done.
- States: IDLE, LOAD, HEADER, PAYLOAD, PARITY, CHECK. data_out=0 in IDLE, LOAD and CHECK.
- IDLE:
  - tx_ready=1.
  - On start=1, latch dest_addr, payload_len and inject_err.
  - If dest_addr==3, payload_len==0 or payload_len>MAX_LEN: pulse req_err next cycle and stay in IDLE.
  - Otherwise go to LOAD with wr_cnt=0.
  - tx_ready=0 in all other states; start outside IDLE is ignored.
- LOAD:
  - src_ready=1.
  - Each cycle with src_valid & src_ready writes buf[wr_cnt] and increments wr_cnt.
  - When the byte with wr_cnt==len-1 is accepted, go to HEADER.
  - src_valid gaps simply stall LOAD.
  - src_ready=0 in all other states.
- HEADER:
  - data_out={len[5:0], addr[1:0]}, pkt_valid=1.
  - Transfer occurs on a rising edge with busy=0; then parity=header, rd_cnt=0, go to PAYLOAD.
- PAYLOAD:
  - data_out=buf[rd_cnt], pkt_valid=1.
  - On transfer: parity ^= byte, rd_cnt++.
  - After the byte with rd_cnt==len-1 transfers, go to PARITY.
  - Payload emission has no bubbles; pkt_valid never drops before the last payload byte.
- PARITY:
  - data_out = parity, XORed with 8'hFF if inject_err was latched; pkt_valid=0.
  - On transfer, go to CHECK with wcnt=0 and err_seen=0.
- busy rule: while busy=1 in HEADER, PAYLOAD or PARITY, data_out, pkt_valid and all counters hold unchanged. busy is ignored in other states.
- CHECK:
  - For ERR_WAIT cycles: err_seen |= err, wcnt++.
  - On the cycle after the last sample: go to IDLE, tx_done=1, tx_err = err_seen | err (final sample included).
  - err outside CHECK is ignored.
- Latency:
  - LOAD takes len cycles minimum.
  - Transmission takes len+2 cycles with busy=0.
  - start to tx_done with no stalls is 1 + len + (len+2) + ERR_WAIT cycles.
- Back-to-back: start may be asserted in the same cycle tx_done pulses, since tx_ready=1 in IDLE.

Test Plan:
- Golden packet: addr=1, len=2, src bytes A5,3C, busy=0 → data_out sequence 09(pv=1), A5(pv=1), 3C(pv=1), 90(pv=0); tx_done after ERR_WAIT cycles with tx_err=0.
- Busy stall: same packet with busy=1 for 4 cycles while 8'hA5 is on data_out → A5 and pkt_valid=1 held all 4 cycles; then 3C, 90; no byte is duplicated or skipped.
- Illegal request: start with addr=3 (len=5), and separately len=0 (addr=0) → req_err pulses 1 cycle each; tx_ready stays 1; pkt_valid never asserted.
- Error path: inject_err=1 with the golden packet → parity byte 6F; router model raises err 2 cycles after parity → tx_done with tx_err=1.
- Max length with gaps: addr=2, len=63, src_valid toggling 50% → header FE, 63 contiguous payload bytes matching input order, parity equal to the XOR of all 64 preceding bytes.
- Reset mid-packet: deassert resetn for 1 cycle during PAYLOAD byte 10 → next cycle pkt_valid=0, data_out=0, tx_ready=1, no tx_done; a following golden packet transmits correctly.
